// File: rtl/seq_divider_pkg.sv
// Shared constants for the sequential divider: FSM encodings and default width.
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dmag,
  input  logic             din,
  output logic [WIDTH-1:0] rem_next,
  output logic             qbit
);

  logic        [WIDTH:0] shifted;
  logic signed [WIDTH:0] trial;

  // rem < dmag keeps |trial| below 2^WIDTH, so bit WIDTH is a reliable borrow flag
  assign shifted  = {rem, din};
  assign trial    = $signed(shifted - {1'b0, dmag});
  assign qbit     = ~trial[WIDTH];
  assign rem_next = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider (unsigned/signed) with start/busy/done handshake.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] rem_p0;
  logic [WIDTH-1:0] quo_p0;
  logic [WIDTH-1:0] dmag_p0;
  logic [CW-1:0]    cnt;
  logic             neg_q;
  logic             neg_r;
  logic             dvz;
  logic [WIDTH-1:0] rem_next;
  logic             qbit;

  // Most-negative input maps to unsigned 2^(WIDTH-1), which fits WIDTH bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sg);
    return (sg && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_p0),
    .dmag     (dmag_p0),
    .din      (quo_p0[WIDTH-1]),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rem_p0      <= '0;
      quo_p0      <= '0;
      dmag_p0     <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dvz         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            neg_q   <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r   <= is_signed & dividend[WIDTH-1];
            dmag_p0 <= magnitude(divisor, is_signed);
            rem_p0  <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            if (divisor == '0) begin
              // raw dividend is kept so it can be returned unmodified as the remainder
              dvz    <= 1'b1;
              quo_p0 <= dividend;
              state  <= FIX;
            end else begin
              dvz    <= 1'b0;
              quo_p0 <= magnitude(dividend, is_signed);
              state  <= RUN;
            end
          end
        end
        // ---- iteration stage: dividend shifts out the top, quotient bits enter the bottom
        RUN: begin
          rem_p0 <= rem_next;
          quo_p0 <= {quo_p0[WIDTH-2:0], qbit};
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        // ---- sign-correction / output stage
        FIX: begin
          state       <= IDLE;
          busy        <= 1'b0;
          done        <= 1'b1;
          div_by_zero <= dvz;
          if (dvz) begin
            quotient  <= '1;
            remainder <= quo_p0;
          end else begin
            quotient  <= cond_neg(quo_p0, neg_q);
            remainder <= cond_neg(rem_p0, neg_r);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=32) with hand-computed expected results.
module tb_seq_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks   = 0;
  int failures = 0;
  int lat;
  int bcnt;
  int dcnt;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents operands with start high across one rising edge; caller positions time.
  task automatic launch(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b);
    start     = 1'b1;
    is_signed = sg;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after acceptance until done, and samples where busy is high.
  task automatic wait_done(output int latency, output int busy_cycles);
    latency     = 0;
    busy_cycles = busy ? 1 : 0;
    while (!done && latency < 200) begin
      @(posedge clk);
      #1;
      latency++;
      if (busy) busy_cycles++;
    end
  endtask

  task automatic run_op(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    launch(sg, a, b);
    wait_done(lat, bcnt);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_dvz", 32'(div_by_zero), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Unsigned 100/7 with latency and busy length
    run_op(1'b0, 32'd100, 32'd7);
    chk("u100_7_lat", 32'(lat), 32'd33);
    chk("u100_7_busy", 32'(bcnt), 32'd33);
    chk("u100_7_q", quotient, 32'd14);
    chk("u100_7_r", remainder, 32'd2);
    chk("u100_7_dvz", 32'(div_by_zero), 32'd0);
    chk("u100_7_busy_at_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("q_held", quotient, 32'd14);

    // Signed sign combinations
    run_op(1'b1, 32'hFFFF_FF9C, 32'd7);
    chk("s_m100_7_q", quotient, 32'hFFFF_FFF2);
    chk("s_m100_7_r", remainder, 32'hFFFF_FFFE);
    run_op(1'b1, 32'd100, 32'hFFFF_FFF9);
    chk("s_100_m7_q", quotient, 32'hFFFF_FFF2);
    chk("s_100_m7_r", remainder, 32'd2);
    run_op(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
    chk("s_m100_m7_q", quotient, 32'd14);
    chk("s_m100_m7_r", remainder, 32'hFFFF_FFFE);

    // Divide by zero
    run_op(1'b0, 32'h1234_5678, 32'd0);
    chk("u_dz_lat", 32'(lat), 32'd1);
    chk("u_dz_q", quotient, 32'hFFFF_FFFF);
    chk("u_dz_r", remainder, 32'h1234_5678);
    chk("u_dz_flag", 32'(div_by_zero), 32'd1);
    run_op(1'b1, 32'h1234_5678, 32'd0);
    chk("s_dz_lat", 32'(lat), 32'd1);
    chk("s_dz_q", quotient, 32'hFFFF_FFFF);
    chk("s_dz_r", remainder, 32'h1234_5678);
    chk("s_dz_flag", 32'(div_by_zero), 32'd1);
    run_op(1'b1, 32'h8765_4321, 32'd0);
    chk("s_dz_neg_r", remainder, 32'h8765_4321);

    // Most-negative / -1, signed and unsigned
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("s_ovf_q", quotient, 32'h8000_0000);
    chk("s_ovf_r", remainder, 32'd0);
    chk("s_ovf_dvz", 32'(div_by_zero), 32'd0);
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("u_big_q", quotient, 32'd0);
    chk("u_big_r", remainder, 32'h8000_0000);

    // start re-pulsed mid-operation is ignored
    @(negedge clk);
    launch(1'b0, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    @(negedge clk);
    launch(1'b0, 32'd9, 32'd3);
    wait_done(lat, bcnt);
    chk("busy_ign_lat", 32'(lat), 32'd27);
    chk("busy_ign_q", quotient, 32'd14);
    chk("busy_ign_r", remainder, 32'd2);

    // Back-to-back: start asserted in the done cycle
    launch(1'b0, 32'd9, 32'd3);
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_old_q_held", quotient, 32'd14);
    wait_done(lat, bcnt);
    chk("b2b_lat", 32'(lat), 32'd33);
    chk("b2b_q", quotient, 32'd3);
    chk("b2b_r", remainder, 32'd0);

    // Asynchronous reset mid-operation
    @(negedge clk);
    launch(1'b0, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_q", quotient, 32'd0);
    chk("arst_r", remainder, 32'd0);
    chk("arst_dvz", 32'(div_by_zero), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) dcnt++;
    end
    chk("arst_no_done", 32'(dcnt), 32'd0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd16);
    chk("post_rst_lat", 32'(lat), 32'd33);
    chk("post_rst_q", quotient, 32'h0FFF_FFFF);
    chk("post_rst_r", remainder, 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
